// File: rtl/elev_pkg.sv
// Shared definitions for the elevator dispatcher: floor sizing, dispatcher
// state encoding and the 50 MHz board timing constants.
package elev_pkg;

    localparam int          NUM_FLOORS            = 4;
    localparam int          FLOOR_W               = 2;
    localparam int          CLK_HZ                = 50_000_000;
    localparam int          MOVE_PULSE_CYCLES     = 4;
    localparam int unsigned ARRIVE_TIMEOUT_CYCLES = 200_000_000;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT
    } dispState_e;

    typedef struct packed {
        logic   valid;
        floor_t floor;
        logic   dirUp;
    } sel_t;

endpackage

// File: rtl/call_sync_edge.sv
// Two-flop synchroniser for one raw call button followed by a single-cycle
// rising-edge pulse, so a held button registers exactly one call.
module call_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/elevator_call_dispatcher.sv
// Collects floor calls, picks the next target with a SCAN policy, issues the
// new_floor/move request to the car controller and waits for arrival.
module elevator_call_dispatcher
    import elev_pkg::*;
#(
    parameter int          MOVE_PULSE     = MOVE_PULSE_CYCLES,
    parameter int unsigned ARRIVE_TIMEOUT = ARRIVE_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn_i,
    input  floor_t                curr_floor_i,
    input  logic                  car_idle_i,
    output floor_t                new_floor_o,
    output logic                  move_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  busy_o,
    output logic                  fault_o
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(ARRIVE_TIMEOUT - 1);
    localparam logic [31:0] PULSE_LAST   = 32'(MOVE_PULSE);

    dispState_e            state_q, state_d;
    floor_t                newFloor_q, newFloor_d;
    logic                  dirUp_q, dirUp_d;
    logic                  fault_q, fault_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [31:0]           cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] clearMask;
    logic [NUM_FLOORS-1:0] pendLive;
    sel_t                  sel;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : gSync
        call_sync_edge uSync (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (call_btn_i[g]),
            .rise_o (rise[g])
        );
    end

    // Nearest pending floor ahead in the current direction, else reverse.
    function automatic sel_t selectTarget(input logic [NUM_FLOORS-1:0] pend,
                                          input floor_t curr, input logic dirUp);
        sel_t   res;
        logic   haveAbove, haveBelow;
        floor_t above, below;
        res       = '0;
        res.dirUp = dirUp;
        haveAbove = 1'b0;
        haveBelow = 1'b0;
        above     = '0;
        below     = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pend[f] && (floor_t'(f) > curr)) begin
                haveAbove = 1'b1;
                above     = floor_t'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pend[f] && (floor_t'(f) < curr)) begin
                haveBelow = 1'b1;
                below     = floor_t'(f);
            end
        end
        if (dirUp ? haveAbove : !haveBelow) begin
            res.valid = haveAbove;
            res.floor = above;
            res.dirUp = haveAbove ? 1'b1 : dirUp;
        end else begin
            res.valid = haveBelow;
            res.floor = below;
            res.dirUp = 1'b0;
        end
        return res;
    endfunction

    always_comb begin
        clearMask = '0;
        if (car_idle_i) clearMask[curr_floor_i] = 1'b1;
        pendLive   = pending_q & ~clearMask;
        pending_d  = (pending_q | rise) & ~clearMask;
        sel        = selectTarget(pendLive, curr_floor_i, dirUp_q);
        state_d    = state_q;
        newFloor_d = newFloor_q;
        dirUp_d    = dirUp_q;
        fault_d    = fault_q;
        cnt_d      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|pendLive) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (sel.valid) begin
                    newFloor_d = sel.floor;
                    dirUp_d    = sel.dirUp;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q >= PULSE_LAST) state_d = ST_WAIT;
                else                     cnt_d   = cnt_q + 32'd1;
            end
            ST_WAIT: begin
                if (car_idle_i && (curr_floor_i == newFloor_q)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            newFloor_q <= '0;
            dirUp_q    <= 1'b1;
            fault_q    <= 1'b0;
            pending_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            newFloor_q <= newFloor_d;
            dirUp_q    <= dirUp_d;
            fault_q    <= fault_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
        end
    end

    // First ISSUE cycle is the new_floor setup cycle, so move starts one later.
    assign move_o      = (state_q == ST_ISSUE) && (cnt_q != '0);
    assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign new_floor_o = newFloor_q;
    assign pending_o   = pending_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Scoreboard bench for elevator_call_dispatcher: a SCAN reference model predicts
// each issued target; a monitor checks every move pulse against the queue.
module tb_elevator_call_dispatcher;
    import elev_pkg::*;

    localparam int PULSE = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] call_btn = '0;
    logic [1:0] curr_floor = '0;
    logic       car_idle = 1'b1;
    logic [1:0] new_floor;
    logic       move;
    logic [3:0] pending;
    logic       busy;
    logic       fault;

    typedef struct {
        int         floorExp;
        logic [3:0] pendExp;
    } exp_t;

    exp_t       expQ[$];
    int         checks = 0;
    int         passes = 0;
    int         riseCount = 0;
    logic [3:0] modelPend = '0;
    int         modelCar = 0;
    bit         modelUp = 1'b1;

    elevator_call_dispatcher #(.MOVE_PULSE(PULSE), .ARRIVE_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_btn_i   (call_btn),
        .curr_floor_i (curr_floor),
        .car_idle_i   (car_idle),
        .new_floor_o  (new_floor),
        .move_o       (move),
        .pending_o    (pending),
        .busy_o       (busy),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference SCAN rule: nearest call ahead in the travel direction, else turn round.
    function automatic void pickTarget(input logic [3:0] pend, input int car, input bit upIn,
                                       output int tgt, output bit upOut);
        int above = -1;
        int below = -1;
        for (int f = 3; f >= 0; f--) if (pend[f] && f > car) above = f;
        for (int f = 0; f < 4; f++)  if (pend[f] && f < car) below = f;
        upOut = upIn;
        if (upIn) begin
            if (above >= 0) tgt = above;
            else begin tgt = below; upOut = 1'b0; end
        end else begin
            if (below >= 0) tgt = below;
            else begin tgt = above; upOut = 1'b1; end
        end
    endfunction

    task automatic applyStimulus(input logic [3:0] mask);
        @(negedge clk);
        call_btn = mask;
        repeat (3) @(negedge clk);
        call_btn = '0;
    endtask

    task automatic waitMove(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (move == level) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) checkOutput("wait_move_level", int'(move), int'(level));
    endtask

    task automatic serviceAll(input logic [3:0] midPressIn);
        int         tgt;
        bit         nu;
        bit         ok;
        logic [3:0] midPress;
        midPress = midPressIn;
        while (modelPend != 0) begin
            pickTarget(modelPend, modelCar, modelUp, tgt, nu);
            modelUp = nu;
            expQ.push_back('{floorExp: tgt, pendExp: modelPend});
            waitMove(1'b1, 40, ok);
            if (!ok) return;
            car_idle = 1'b0;
            waitMove(1'b0, 40, ok);
            if (!ok) return;
            if (midPress != 0) begin
                applyStimulus(midPress);
                modelPend = modelPend | midPress;
                checkOutput("wait_floor_locked", int'(new_floor), tgt);
                checkOutput("wait_pending", int'(pending), int'(modelPend));
                midPress = '0;
            end
            repeat ($urandom_range(1, 5)) @(negedge clk);
            curr_floor    = 2'(tgt);
            car_idle      = 1'b1;
            modelCar      = tgt;
            modelPend[tgt] = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("idle_pending", int'(pending), int'(modelPend));
        checkOutput("idle_busy", int'(busy), 0);
    endtask

    // Monitor: every move rising edge must match the oldest expected request.
    initial begin
        logic       prevMove = 1'b0;
        logic [1:0] prevFloor = '0;
        int         highCnt = 0;
        int         curExp = -1;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevMove = 1'b0;
                highCnt  = 0;
                prevFloor = new_floor;
            end else begin
                if (move && !prevMove) begin
                    riseCount++;
                    highCnt = 1;
                    checkOutput("move_expected", (expQ.size() != 0) ? 1 : 0, 1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        curExp = e.floorExp;
                        checkOutput("issue_target", int'(new_floor), e.floorExp);
                        checkOutput("issue_pending", int'(pending), int'(e.pendExp));
                        checkOutput("issue_setup", int'(prevFloor), e.floorExp);
                        checkOutput("issue_busy", int'(busy), 1);
                    end else begin
                        curExp = -1;
                    end
                end else if (move && prevMove) begin
                    highCnt++;
                end else if (!move && prevMove) begin
                    checkOutput("move_width", highCnt, PULSE);
                    if (curExp >= 0) checkOutput("floor_hold", int'(new_floor), curExp);
                end
                prevMove  = move;
                prevFloor = new_floor;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         ok;
        bit         nu;
        int         tgt;
        int         n;
        int         riseBefore;
        logic [3:0] mask;
        logic [3:0] mid;

        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_new_floor", int'(new_floor), 0);
        checkOutput("rst_move", int'(move), 0);
        checkOutput("rst_pending", int'(pending), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_fault", int'(fault), 0);

        $display("[TB] single call, input latency");
        call_btn = 4'b0100;
        repeat (2) @(negedge clk);
        checkOutput("pend_latency2", int'(pending), 0);
        @(negedge clk);
        checkOutput("pend_latency3", int'(pending), 4);
        call_btn  = '0;
        modelPend = 4'b0100;
        serviceAll('0);

        $display("[TB] call at current floor, held button");
        @(negedge clk);
        call_btn = 4'b0100;
        repeat (6) @(negedge clk);
        checkOutput("same_floor_pending", int'(pending), 0);
        checkOutput("same_floor_busy", int'(busy), 0);
        car_idle = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("held_single_set", int'(pending), 0);
        call_btn = '0;
        car_idle = 1'b1;
        @(negedge clk);

        $display("[TB] SCAN from floor 1 with calls 0 and 3");
        curr_floor = 2'd1;
        modelCar   = 1;
        applyStimulus(4'b1001);
        modelPend = modelPend | (4'b1001 & ~(4'b0001 << modelCar));
        serviceAll('0);

        $display("[TB] new call during WAIT");
        applyStimulus(4'b1000);
        modelPend = modelPend | (4'b1000 & ~(4'b0001 << modelCar));
        serviceAll(4'b0010);

        $display("[TB] arrival timeout");
        applyStimulus(4'b0100);
        modelPend = modelPend | (4'b0100 & ~(4'b0001 << modelCar));
        pickTarget(modelPend, modelCar, modelUp, tgt, nu);
        modelUp = nu;
        expQ.push_back('{floorExp: tgt, pendExp: modelPend});
        waitMove(1'b1, 40, ok);
        car_idle = 1'b0;
        waitMove(1'b0, 40, ok);
        n = 0;
        while (n < TMO + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (fault) break;
        end
        checkOutput("timeout_cycles", n, TMO);
        checkOutput("timeout_fault", int'(fault), 1);
        checkOutput("timeout_busy", int'(busy), 0);
        checkOutput("timeout_pending", int'(pending), int'(modelPend));
        serviceAll('0);
        checkOutput("fault_sticky", int'(fault), 1);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 12; r++) begin
            mask = 4'($urandom_range(1, 15));
            mid  = ($urandom_range(0, 1) == 1) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            applyStimulus(mask);
            modelPend = modelPend | (mask & ~(4'(4'b0001 << modelCar)));
            serviceAll(mid);
        end

        $display("[TB] reset during ISSUE");
        mask = 4'(4'b0001 << ((modelCar + 1) % 4));
        applyStimulus(mask);
        modelPend = mask;
        pickTarget(modelPend, modelCar, modelUp, tgt, nu);
        expQ.push_back('{floorExp: tgt, pendExp: modelPend});
        waitMove(1'b1, 40, ok);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_move", int'(move), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_pending", int'(pending), 0);
        checkOutput("async_rst_fault", int'(fault), 0);
        checkOutput("async_rst_floor", int'(new_floor), 0);
        riseBefore = riseCount;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        modelPend = '0;
        modelUp   = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("no_move_after_rst", riseCount, riseBefore);
        checkOutput("pending_after_rst", int'(pending), 0);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
